// File: rtl/sync_fifo32x512_if.sv
// sync_fifo32x512_if: producer/consumer signal bundle for the 512x32 FWFT FIFO.
interface sync_fifo32x512_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG2 = 9
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic wren;
  logic rden;
  logic full;
  logic almost_full;
  logic overflow;
  logic empty;
  logic almost_empty;
  logic underflow;
  logic [DEPTH_LOG2:0] data_count;
  modport master (
    output din, wren, rden,
    input dout, full, almost_full, overflow, empty, almost_empty, underflow, data_count
  );
  modport slave (
    input din, wren, rden,
    output dout, full, almost_full, overflow, empty, almost_empty, underflow, data_count
  );
endinterface

// File: rtl/sync_fifo32x512.sv
// sync_fifo32x512: single-clock 512x32 block-RAM FIFO with first-word-fall-through output.
module sync_fifo32x512 #(
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input logic CLK,
  input logic RESET,
  sync_fifo32x512_if.slave f
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d, ram_cnt;
  logic [WIDTH-1:0] dout_q;
  logic valid_q, full_q, afull_q, aempty_q, ovf_q, unf_q;
  logic wr, pop, load;
  // ram_cnt counts words still in RAM; the head word lives in dout_q once prefetched
  always_comb begin
    wr = f.wren && !full_q;
    pop = f.rden && valid_q;
    ram_cnt = count_q - CW'(valid_q);
    load = (ram_cnt != '0) && (!valid_q || pop);
    count_d = count_q + CW'(wr) - CW'(pop);
  end
  always_ff @(posedge CLK) begin
    if (wr && !RESET) mem[wr_ptr_q] <= f.din;
    if (RESET) dout_q <= '0;
    else if (load) dout_q <= mem[rd_ptr_q];
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q <= 1'b0;
      afull_q <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(wr);
      rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(load);
      count_q <= count_d;
      valid_q <= load || (valid_q && !pop);
      full_q <= count_d == DEPTH;
      afull_q <= count_d >= DEPTH - CW'(1);
      aempty_q <= count_d <= CW'(1);
      ovf_q <= f.wren && full_q;
      unf_q <= f.rden && !valid_q;
    end
  end
  assign f.dout = dout_q;
  assign f.empty = !valid_q;
  assign f.full = full_q;
  assign f.almost_full = afull_q;
  assign f.almost_empty = aempty_q;
  assign f.overflow = ovf_q;
  assign f.underflow = unf_q;
  assign f.data_count = count_q;
endmodule

// File: tb/tb_sync_fifo32x512.sv
// tb_sync_fifo32x512: scoreboard bench for the 512x32 FWFT FIFO.
module tb_sync_fifo32x512;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int fails = 0;
  int m_cnt = 0;
  bit m_valid = 1'b0;
  bit e_ovf, e_unf;
  logic [31:0] q[$];
  sync_fifo32x512_if bus();
  sync_fifo32x512 dut (.CLK(clk), .RESET(RESET), .f(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_state();
    chk("cnt", 32'(bus.data_count), m_cnt);
    chk("empty", 32'(bus.empty), 32'(!m_valid));
    chk("full", 32'(bus.full), 32'(m_cnt == 512));
    chk("afull", 32'(bus.almost_full), 32'(m_cnt >= 511));
    chk("aempty", 32'(bus.almost_empty), 32'(m_cnt <= 1));
    chk("ovf", 32'(bus.overflow), 32'(e_ovf));
    chk("unf", 32'(bus.underflow), 32'(e_unf));
    if (m_valid) chk("dout", bus.dout, q[0]);
  endtask
  task automatic cyc(input bit w, input logic [31:0] d, input bit r);
    bit acc_w, acc_p, ld;
    bus.wren = w;
    bus.din = d;
    bus.rden = r;
    acc_w = w && m_cnt < 512;
    acc_p = r && m_valid;
    ld = (m_cnt - int'(m_valid)) > 0 && (!m_valid || acc_p);
    e_ovf = w && m_cnt == 512;
    e_unf = r && !m_valid;
    if (acc_p) begin
      chk("pop", bus.dout, q[0]);
      void'(q.pop_front());
    end
    if (acc_w) q.push_back(d);
    m_cnt += int'(acc_w) - int'(acc_p);
    m_valid = ld || (m_valid && !acc_p);
    @(posedge clk);
    #1;
    check_state();
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    bus.wren = 1'b1;
    bus.rden = 1'b1;
    bus.din = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    m_cnt = 0;
    m_valid = 1'b0;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    q.delete();
    check_state();
    chk("rst_dout", bus.dout, 32'h0);
  endtask
  task automatic drain();
    for (int i = 0; i < 2000 && q.size() > 0; i++) cyc(1'b0, 32'h0, m_valid);
    chk("drained", q.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic [31:0] burst[6];
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    cyc(1'b0, 32'h0, 1'b0);
    // single word: visible one edge after the write edge
    cyc(1'b1, 32'h0000_0140, 1'b0);
    chk("lat_empty", 32'(bus.empty), 32'h1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("vis_dout", bus.dout, 32'h0000_0140);
    chk("vis_aempty", 32'(bus.almost_empty), 32'h1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("pop_empty", 32'(bus.empty), 32'h1);
    // burst with consumer popping whenever a word is visible
    burst = '{32'h0, 32'h0, 32'h0, 32'h0000_0140, 32'h0012_0000, 32'h3C23_D70A};
    foreach (burst[i]) cyc(1'b1, burst[i], m_valid);
    drain();
    // fill to full, then overflow attempt
    for (int i = 0; i < 512; i++) begin
      cyc(1'b1, 32'(i), 1'b0);
      if (i == 510) chk("afull511", 32'(bus.almost_full), 32'h1);
    end
    chk("full512", 32'(bus.full), 32'h1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf_pulse", 32'(bus.overflow), 32'h1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("ovf_clear", 32'(bus.overflow), 32'h0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1);
    drain();
    // wrap test with occupancy held between 100 and 300
    n = 0;
    for (int i = 0; i < 5000 && n < 700; i++) begin
      bit w, r;
      w = m_cnt < 100 || (m_cnt < 300 && $urandom_range(0, 1) == 1);
      r = m_cnt > 100 && m_valid && $urandom_range(0, 1) == 1;
      if (w) n++;
      cyc(w, $urandom, r);
    end
    chk("wrap_n", n, 700);
    drain();
    cyc(1'b0, 32'h0, 1'b1);
    chk("unf_pulse", 32'(bus.underflow), 32'h1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("unf_clear", 32'(bus.underflow), 32'h0);
    // reset while holding 200 words
    for (int i = 0; i < 200; i++) cyc(1'b1, 32'(i + 1000), 1'b0);
    do_reset();
    chk("rst_cnt", 32'(bus.data_count), 32'h0);
    cyc(1'b1, 32'h3C23_D70A, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("post_rst", bus.dout, 32'h3C23_D70A);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
